// File: rtl/video_pkg.sv
// video_pkg: frame geometry, pixel/beat types and RGB444 -> 30-bit expansion shared by the frame reader.
package video_pkg;
  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  typedef logic [11:0] rgb444_t;
  typedef struct packed {logic [29:0] data; logic sop; logic eop;} st_beat_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} rd_state_t;
  function automatic logic [29:0] expand444(rgb444_t c);
    return {c[11:8], c[11:8], 2'b00, c[7:4], c[7:4], 2'b00, c[3:0], c[3:0], 2'b00};
  endfunction
endpackage

// File: rtl/frame_stream_reader_if.sv
// frame_stream_reader_if: Avalon-ST video beat with valid/ready backpressure.
interface frame_stream_reader_if;
  logic [29:0] data_out;
  logic valid_out, startofpacket_out, endofpacket_out, ready_in;
  modport master (output data_out, valid_out, startofpacket_out, endofpacket_out, input ready_in);
  modport slave (input data_out, valid_out, startofpacket_out, endofpacket_out, output ready_in);
endinterface

// File: rtl/frame_stream_reader_fifo.sv
// stream_fifo: show-ahead synchronous FIFO of stream beats; head reads as zero while empty.
module stream_fifo
  import video_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  st_beat_t      wr_data,
  input  logic          rd_en,
  output st_beat_t      rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);
  st_beat_t mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic pop;
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign pop = rd_en && !empty;
  assign rd_data = empty ? '0 : mem_q[rp_q];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q == PW'(DEPTH - 1) ? '0 : wp_q + PW'(1);
      if (pop) rp_q <= rp_q == PW'(DEPTH - 1) ? '0 : rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wp_q] <= wr_data;
endmodule

// File: rtl/frame_stream_reader.sv
// frame_stream_reader: sweeps the image RAM in raster order and streams one frame as an Avalon-ST packet.
// FRAME_READER_TEST_PATTERN_EN replaces RAM pixels with 8 vertical colour bars.
module frame_stream_reader
  import video_pkg::*;
#(
  parameter int WIDTH = IMG_W,
  parameter int HEIGHT = IMG_H,
  parameter int ADDR_W = 17,
  parameter int PIX_W = 12,
  parameter int RD_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_start,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [PIX_W-1:0]     rd_data,
  frame_stream_reader_if.master st,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  rd_state_t state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] vld_q, sop_q, eop_q;
  logic done_q, ovr_q, xfer;
  logic [CW-1:0] fifo_cnt;
  logic fifo_empty;
  st_beat_t wr_beat, rd_beat;
  rgb444_t pix;
  assign busy = state_q != IDLE;
  // vld_q holds every read not yet written to the FIFO, so fifo + vld_q bounds the occupancy
  assign rd_en = state_q == FETCH && enable && (32'(fifo_cnt) + 32'($countones(vld_q))) < 32'(FIFO_DEPTH);
  assign rd_addr = addr_q;
  assign xfer = st.valid_out && st.ready_in;
  assign wr_beat = '{data: expand444(pix), sop: sop_q[RD_LAT-1], eop: eop_q[RD_LAT-1]};
  assign st.valid_out = !fifo_empty;
  assign st.data_out = rd_beat.data;
  assign st.startofpacket_out = rd_beat.sop;
  assign st.endofpacket_out = rd_beat.eop;
  assign frame_done = done_q;
  assign overrun = ovr_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      vld_q <= '0;
      sop_q <= '0;
      eop_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      vld_q <= RD_LAT'({vld_q, rd_en});
      sop_q <= RD_LAT'({sop_q, rd_en && addr_q == '0});
      eop_q <= RD_LAT'({eop_q, rd_en && addr_q == LAST});
      done_q <= xfer && st.endofpacket_out;
      ovr_q <= frame_start && busy;
      if (rd_en) addr_q <= addr_q + ADDR_W'(1);
      case (state_q)
        IDLE: if (frame_start) begin
          state_q <= FETCH;
          addr_q <= '0;
        end
        FETCH: if (rd_en && addr_q == LAST) state_q <= DRAIN;
        DRAIN: if (xfer && st.endofpacket_out) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
`ifdef FRAME_READER_TEST_PATTERN_EN
  localparam int XW = $clog2(WIDTH);
  localparam logic [95:0] BARS = {12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};
  logic [XW-1:0] col_q;
  logic [RD_LAT-1:0][11:0] pat_q;
  logic [2:0] bar;
  logic unused_rd;
  assign unused_rd = ^rd_data;
  assign bar = 3'(32'(col_q) / (WIDTH / 8));
  assign pix = pat_q[RD_LAT-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      col_q <= '0;
      pat_q <= '0;
    end else begin
      pat_q <= (RD_LAT * 12)'({pat_q, BARS[bar * 12 +: 12]});
      if (state_q == IDLE && frame_start) col_q <= '0;
      else if (rd_en) col_q <= col_q == XW'(WIDTH - 1) ? '0 : col_q + XW'(1);
    end
`else
  assign pix = rgb444_t'(rd_data);
`endif
  stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .wr_en(vld_q[RD_LAT-1]), .wr_data(wr_beat),
    .rd_en(xfer), .rd_data(rd_beat), .empty(fifo_empty), .count(fifo_cnt)
  );
endmodule

// File: tb/tb_frame_stream_reader.sv
// tb_frame_stream_reader: directed table plus frame-level sequences on a 16x4 frame.
module tb_frame_stream_reader;
  localparam int W = 16, H = 4, N = W * H, AW = 6;
  typedef struct packed {logic fs, en, rdy, rd, busy, v, sop; logic [7:0] addr;} vec_t;
  logic clk = 0, reset = 0, enable = 0, frame_start = 0;
  logic rd_en, busy, frame_done, overrun;
  logic [AW-1:0] rd_addr;
  logic [11:0] rd_data = '0, d1 = '0;
  logic [11:0] ram [N];
`ifdef FRAME_READER_TEST_PATTERN_EN
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif
  int tests = 0, fails = 0, nb = 0, na = 0, issued = 0, xfered = 0, done_cnt = 0;
  logic exp_ovr = 0, exp_done = 0, stalled = 0;
  frame_stream_reader_if sif ();
  frame_stream_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .PIX_W(12), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .st(sif), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    d1 <= ram[rd_addr];
    rd_data <= d1;
  end
  function automatic logic [29:0] exp30(int i);
    logic [11:0] p;
`ifdef FRAME_READER_TEST_PATTERN_EN
    p = bars[(i % W) / (W / 8)];
`else
    p = ram[i];
`endif
    return {p[11:8], p[11:8], 2'b00, p[7:4], p[7:4], 2'b00, p[3:0], p[3:0], 2'b00};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear();
    nb = 0; na = 0; issued = 0; xfered = 0; done_cnt = 0; stalled = 0;
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_valid"}, sif.valid_out, 0);
    chk({tag, "_data"}, sif.data_out, 0);
    chk({tag, "_sop"}, sif.startofpacket_out, 0);
    chk({tag, "_eop"}, sif.endofpacket_out, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask
  // one clock: drive inputs after the falling edge, check just before the rising edge
  task automatic cyc(input logic fs, input logic en, input logic rdy);
    logic xf;
    @(negedge clk);
    frame_start = fs; enable = en; sif.ready_in = rdy;
    #4;
    chk("overrun", overrun, exp_ovr);
    chk("frame_done", frame_done, exp_done);
    if (stalled) chk("hold_valid", sif.valid_out, 1);
    if (!en) chk("rd_en_disabled", rd_en, 0);
    if (rd_en) begin
      chk("rd_addr", rd_addr, na);
      chk("credit", (issued - xfered) < 4, 1);
    end
    if (sif.valid_out) begin
      chk("beat_in_range", nb < N, 1);
      if (nb < N) begin
        chk("data", sif.data_out, exp30(nb));
        chk("sop", sif.startofpacket_out, nb == 0);
        chk("eop", sif.endofpacket_out, nb == N - 1);
      end
    end
    xf = sif.valid_out && rdy;
    exp_ovr = fs && busy;
    exp_done = xf && sif.endofpacket_out;
    stalled = sif.valid_out && !rdy;
    if (rd_en) begin na++; issued++; end
    if (xf) begin nb++; xfered++; end
    if (frame_done) done_cnt++;
  endtask
  task automatic run(input int rmode, input int dis_at, input int ovr_at, input bit eop_fs, input int stop_at);
    int k = 0, off = 0, boff = 0, bo;
    bit ov = 0;
    logic rdy, en, fs;
    while (done_cnt == 0 && nb != stop_at && k < 3000) begin
      rdy = rmode == 0 || (k % 10) < 3;
      if (nb >= dis_at && off == 0) off = 1;
      en = !(off >= 1 && off <= 50);
      fs = (nb == ovr_at && !ov) || (eop_fs && nb == N - 1 && rdy);
      if (nb == ovr_at && fs) ov = 1;
      bo = nb;
      cyc(fs, en, rdy);
      if (!en) boff += nb - bo;
      if (off > 0) off++;
      k++;
    end
    chk("run_budget", k < 3000, 1);
    if (dis_at < N) chk("beats_while_disabled", boff <= 4, 1);
  endtask
  task automatic end_frame();
    chk("beat_count", nb, N);
    chk("frame_done_count", done_cnt, 1);
    cyc(0, 1, 1);
    chk("idle_after_frame", busy, 0);
    clear();
  endtask
  initial begin
    vec_t tbl [17];
    tbl = '{
      {7'b1110000, 8'd0}, {7'b0111100, 8'd0}, {7'b0111100, 8'd1}, {7'b0111100, 8'd2},
      {7'b0111111, 8'd3}, {7'b0111110, 8'd4}, {7'b0101110, 8'd5}, {7'b0100110, 8'd6},
      {7'b0100110, 8'd6}, {7'b0100110, 8'd6}, {7'b0110110, 8'd6}, {7'b0111110, 8'd6},
      {7'b0010110, 8'd7}, {7'b0010110, 8'd7}, {7'b0010110, 8'd7}, {7'b0010100, 8'd7},
      {7'b0111100, 8'd7}};
    for (int i = 0; i < N; i++) ram[i] = 12'($urandom);
    sif.ready_in = 0;
    repeat (3) @(negedge clk);
    rst_chk("reset");
    reset = 1;
    clear();
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].fs, tbl[i].en, tbl[i].rdy);
      chk("tbl_rd_en", rd_en, tbl[i].rd);
      chk("tbl_rd_addr", rd_addr, tbl[i].addr);
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_valid", sif.valid_out, tbl[i].v);
      chk("tbl_sop", sif.startofpacket_out, tbl[i].sop);
    end
    run(0, N + 1, 10, 1, -1);
    end_frame();
    cyc(1, 1, 0);
    run(1, 30, N + 1, 0, -1);
    end_frame();
    cyc(1, 1, 1);
    run(0, N + 1, N + 1, 0, 20);
    chk("reached_beat20", nb, 20);
    @(negedge clk);
    #2 reset = 0;
    #1 rst_chk("async_reset");
    @(negedge clk);
    reset = 1;
    clear();
    exp_ovr = 0; exp_done = 0;
    cyc(1, 1, 1);
    chk("restart_addr", rd_addr, 0);
    run(0, N + 1, N + 1, 0, -1);
    end_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
